uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Purpose : 8N1 UART transmitter. Accepts one byte through a valid/ready
//           handshake and shifts it out as start bit, eight data bits (LSB
//           first) and a stop bit, each held CLOCK_FREQ/BAUD_RATE clock cycles.
// Ports   :
//   clk           in   1  rising-edge clock for all state
//   rst           in   1  asynchronous active-high reset
//   data_in       in   8  byte to send, captured on handshake only
//   data_in_valid in   1  producer offers data_in
//   data_in_ready out  1  high while idle (byte can be accepted)
//   serial_out    out  1  TX line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   // Keep at least one counter bit so a degenerate 1-cycle symbol still builds.
   localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [3:0]       BIT_LAST = 4'd9;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [CNT_W-1:0] w_clk_cnt_next;
   logic [3:0]       r_bit_cnt;
   logic [3:0]       w_bit_cnt_next;
   logic [9:0]       r_shift;
   logic [9:0]       w_shift_next;
   logic             r_serial;
   logic             w_serial_next;
   logic             r_ready;
   logic             w_ready_next;
   logic             w_handshake;
   logic             w_symbol_end;

   assign data_in_ready = r_ready;
   assign serial_out    = r_serial;

   // Next-state and next-output logic for the IDLE/SEND machine.
   always_comb begin
      w_state_next   = r_state;
      w_clk_cnt_next = r_clk_cnt;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_serial_next  = r_serial;
      w_ready_next   = r_ready;
      w_handshake    = data_in_valid & r_ready;
      w_symbol_end   = (r_clk_cnt == CNT_LAST);

      case (r_state)
         IDLE: begin
            if (w_handshake) begin
               // Start bit goes out on the very next cycle; frame bit 0 is it.
               w_state_next   = SEND;
               w_shift_next   = {1'b1, data_in, 1'b0};
               w_serial_next  = 1'b0;
               w_ready_next   = 1'b0;
               w_clk_cnt_next = {CNT_W{1'b0}};
               w_bit_cnt_next = 4'd0;
            end else begin
               w_serial_next  = 1'b1;
               w_ready_next   = 1'b1;
            end
         end
         SEND: begin
            if (w_symbol_end) begin
               w_clk_cnt_next = {CNT_W{1'b0}};
               if (r_bit_cnt == BIT_LAST) begin
                  // Stop bit has been held its full time: back to idle.
                  w_state_next   = IDLE;
                  w_serial_next  = 1'b1;
                  w_ready_next   = 1'b1;
                  w_bit_cnt_next = 4'd0;
                  w_shift_next   = 10'd0;
               end else begin
                  // Shift register LSB always mirrors the bit on the line.
                  w_bit_cnt_next = r_bit_cnt + 4'd1;
                  w_shift_next   = {1'b0, r_shift[9:1]};
                  w_serial_next  = r_shift[1];
               end
            end else begin
               w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
               w_serial_next  = r_shift[0];
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_clk_cnt_next = {CNT_W{1'b0}};
            w_bit_cnt_next = 4'd0;
            w_shift_next   = 10'd0;
            w_serial_next  = 1'b1;
            w_ready_next   = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset forces the line high immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_clk_cnt <= {CNT_W{1'b0}};
         r_bit_cnt <= 4'd0;
         r_shift   <= 10'd0;
         r_serial  <= 1'b1;
         r_ready   <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_clk_cnt <= w_clk_cnt_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_shift   <= w_shift_next;
         r_serial  <= w_serial_next;
         r_ready   <= w_ready_next;
      end
   end

endmodule
